// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding an 8N1 UART serializer (LSB first, idle high).
// Bytes arrive as single-cycle strobes with no backpressure; a push into a full
// FIFO is dropped and latched in a sticky overflow flag unless a pop coincides.
module uart_tx_buffer #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       txd,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              BW        = $clog2(CLK_PER_BIT);
  localparam logic [AW:0]     CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          txd_next;
  logic          pop, push;

  // FIFO handshake: pop only from a registered non-empty FIFO while idle, so a
  // byte written this cycle can never leave in the same cycle.
  always_comb begin
    pop        = (state == IDLE) && !empty;
    push       = in_valid && (!full || pop);
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;
  end

  // Byte storage; writes during reset are ignored.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wptr] <= in_data;
  end

  // FIFO pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_FULL);
      if (in_valid && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Serializer next-state: txd is computed one cycle ahead so the line is a flop.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    idx_next   = idx;
    shift_next = shift;
    txd_next   = txd;
    case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (pop) begin
          state_next = START;
          baud_next  = '0;
          shift_next = mem[rptr];
          txd_next   = 1'b0;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
          txd_next   = shift[0];
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (idx == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            idx_next = idx + 3'd1;
            txd_next = shift[idx + 3'd1];
          end
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
          txd_next   = 1'b1;
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // Serializer state register; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      baud  <= baud_next;
      idx   <= idx_next;
      shift <= shift_next;
      txd   <= txd_next;
      busy  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized and directed stimulus against a queue-based
// frame model, plus a mid-bit line decoder that recovers transmitted bytes.
module tb_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       txd, empty, full, busy, overflow;

  uart_tx_buffer #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .txd      (txd),
    .empty    (empty),
    .full     (full),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: FIFO contents, frame in flight and its elapsed cycle
  logic [7:0] q[$];
  logic       m_in_frame = 1'b0;
  int         m_e        = 0;
  logic [7:0] m_cur      = '0;
  logic       m_ovf      = 1'b0;
  logic [7:0] m_sent[$];

  // line decoder
  logic       d_active = 1'b0;
  int         d_cnt    = 0;
  logic [7:0] d_byte   = '0;
  logic       prev_txd = 1'b1;
  logic [7:0] rx[$];
  int         falls[$];
  int         cycle = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic exp_txd();
    if (!m_in_frame)     return 1'b1;
    if (m_e < CPB)       return 1'b0;
    if (m_e < 9 * CPB)   return m_cur[(m_e - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [31:0] rx_at(input int i);
    if (rx.size() > i) return {24'h0, rx[i]};
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] sent_at(input int i);
    if (m_sent.size() > i) return {24'h0, m_sent[i]};
    return 32'hBEEF;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    if (r) begin
      q.delete();
      m_sent.delete();
      m_in_frame = 1'b0;
      m_e        = 0;
      m_ovf      = 1'b0;
      return;
    end
    if (m_in_frame) begin
      m_e++;
      if (m_e == FRAME) m_in_frame = 1'b0;
    end else if (q.size() > 0) begin
      m_cur      = q.pop_front();
      m_in_frame = 1'b1;
      m_e        = 0;
      m_sent.push_back(m_cur);
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else                  m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    cycle++;
    check("txd",      txd,      exp_txd());
    check("busy",     busy,     m_in_frame);
    check("empty",    empty,    q.size() == 0);
    check("full",     full,     q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    if (r) begin
      d_active = 1'b0;
      rx.delete();
      falls.delete();
    end else if (d_active) begin
      d_cnt++;
      if (d_cnt >= CPB && d_cnt < 9 * CPB && (d_cnt % CPB) == CPB / 2)
        d_byte[(d_cnt - CPB) / CPB] = txd;
      if (d_cnt == FRAME - 2) begin
        check("stop_bit", txd, 1);
        rx.push_back(d_byte);
        d_active = 1'b0;
      end
    end else if (prev_txd && !txd) begin
      d_active = 1'b1;
      d_cnt    = 0;
      falls.push_back(cycle);
    end
    prev_txd = txd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_logs();
    rx.delete();
    falls.delete();
    m_sent.delete();
  endtask

  initial begin
    int         busy_cnt;
    int         k;
    logic [7:0] b;
    logic [7:0] exp_bytes[$];

    // reset state
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    check("rst_txd",   txd,   1);
    check("rst_empty", empty, 1);

    // single 0x55 frame
    step(1'b1, 8'h55, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      busy_cnt += int'(busy);
    end
    check("s55_busy_cycles", busy_cnt, FRAME);
    check("s55_rx_count",    rx.size(), 1);
    check("s55_rx0",         rx_at(0), 8'h55);

    // three back-to-back bytes, frame spacing
    clear_logs();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    idle(140);
    check("s3_rx_count", rx.size(), 3);
    check("s3_rx0", rx_at(0), 8'h01);
    check("s3_rx1", rx_at(1), 8'hFF);
    check("s3_rx2", rx_at(2), 8'h00);
    check("s3_gap01", (falls.size() > 1) ? falls[1] - falls[0] : -1, FRAME + 1);
    check("s3_gap12", (falls.size() > 2) ? falls[2] - falls[1] : -1, FRAME + 1);

    // overflow while a frame is in flight
    clear_logs();
    step(1'b1, 8'hC3, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    check("ovf_full", full, 1);
    check("ovf_set",  overflow, 1);
    idle(300);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", empty, 1);
    check("ovf_rx_count", rx.size(), 5);
    check("ovf_rx4", rx_at(4), 8'h13);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", overflow, 0);

    // push into full FIFO on the pop edge
    clear_logs();
    step(1'b1, 8'hA0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
    k = 0;
    while (k < 200 && !(!m_in_frame && q.size() == DEPTH)) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("fp_sync", k < 200, 1);
    step(1'b1, 8'hEE, 1'b0);
    check("fp_full", full, 1);
    check("fp_no_ovf", overflow, 0);
    idle(320);
    check("fp_rx_count", rx.size(), 6);
    check("fp_rx1", rx_at(1), 8'hB0);
    check("fp_rx5", rx_at(5), 8'hEE);

    // reset in the middle of data bit 3 of 0xA5 with two bytes queued
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    k = 0;
    while (k < 100 && !(m_in_frame && m_e == CPB + 3 * CPB + 1)) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("mr_sync", k < 100, 1);
    check("mr_queued", q.size(), 2);
    step(1'b0, 8'h00, 1'b1);
    check("mr_txd", txd, 1);
    check("mr_empty", empty, 1);
    check("mr_busy", busy, 0);
    idle(100);
    check("mr_no_frames", falls.size(), 0);

    // twelve bytes, paced to avoid overflow, pointers wrap
    clear_logs();
    exp_bytes.delete();
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 12));
      k = 0;
      while (k < 200 && q.size() >= DEPTH) begin
        step(1'b0, 8'h00, 1'b0);
        k++;
      end
      b = 8'($urandom);
      exp_bytes.push_back(b);
      step(1'b1, b, 1'b0);
    end
    idle(600);
    check("w12_rx_count", rx.size(), 12);
    check("w12_no_ovf", overflow, 0);
    for (int i = 0; i < 12; i++) check("w12_rx", rx_at(i), {24'h0, exp_bytes[i]});

    // random traffic
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 4, 8'($urandom), 1'b0);
    idle(300);
    check("rnd_rx_count", rx.size(), m_sent.size());
    for (int i = 0; i < rx.size(); i++) check("rnd_rx", rx_at(i), sent_at(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter CLK_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter DEPTH, default 16, meaning byte FIFO entries; power of two, range 2..256.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  byte from the CPU output port (top-level output_data).
REQ-006 in_valid  input  1  one-cycle strobe qualifying in_data (top-level valid); no backpressure to source.
REQ-007 txd  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 empty  output  1  FIFO holds zero bytes.
REQ-009 full  output  1  FIFO holds DEPTH bytes.
REQ-010 busy  output  1  serializer not in IDLE.
REQ-011 overflow  output  1  sticky: a byte was dropped because FIFO was full.

Function
REQ-012 FIFO: circular buffer, read/write pointers wrap modulo DEPTH, occupancy counter width clog2(DEPTH)+1, range 0..DEPTH.
REQ-013 Push: in_valid=1 with FIFO not full -> in_data written at wptr on that edge; empty deasserts from next cycle.
REQ-014 Push when full and no pop in same cycle -> byte dropped, pointers/count unchanged, overflow set next cycle.
REQ-015 Push when full with pop in same cycle -> push accepted, count stays DEPTH, overflow not set.
REQ-016 Byte pushed into empty FIFO SHALL NOT be popped in the same cycle; earliest pop is the following cycle.
REQ-017 in_valid held high multiple cycles -> one push per cycle (each cycle is a distinct byte).
REQ-018 Serializer states: IDLE, START, DATA, STOP.
REQ-019 IDLE: txd=1; if FIFO not empty -> pop byte into shift register, go START; else stay.
REQ-020 START: txd=0 for CLK_PER_BIT cycles, then DATA with bit index 0.
REQ-021 DATA: txd=shift[index] for CLK_PER_BIT cycles each, index 0..7; after bit 7 -> STOP.
REQ-022 STOP: txd=1 for CLK_PER_BIT cycles, then IDLE.
REQ-023 Frame timing: txd falls on the cycle after the pop edge; frame occupies exactly 10*CLK_PER_BIT cycles; consecutive frames separated by exactly one IDLE cycle (frame period 10*CLK_PER_BIT+1).
REQ-024 Baud counter counts 0..CLK_PER_BIT-1 and wraps to 0 on each bit boundary; reloaded to 0 on entry to START.
REQ-025 txd, busy, empty, full driven from registers (no combinational path from in_valid/in_data to outputs).
REQ-026 busy=1 in START, DATA, STOP; 0 in IDLE.
REQ-027 Popped byte is held in shift register; subsequent FIFO writes do not alter the frame in flight.

Reset
REQ-028 reset=1 on an edge -> state IDLE, pointers 0, count 0, baud counter 0, bit index 0, txd=1, empty=1, full=0, busy=0, overflow=0, from the next cycle.
REQ-029 Reset mid-frame aborts the frame: txd returns high the cycle after reset; queued bytes discarded; no partial frame resumes.
REQ-030 in_valid during reset ignored; overflow clears only on reset.

Verification (CLK_PER_BIT=4, DEPTH=4)
REQ-031 Push 0x55 once into idle block -> txd low cycles 1-4 after pop, then bits 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy high 40 cycles; empty back to 1 after pop.
REQ-032 Push 0x01,0xFF,0x00 on consecutive cycles -> three frames decode to 0x01,0xFF,0x00 in order; frame starts spaced exactly 41 cycles apart.
REQ-033 While frame 1 in flight, push 5 bytes back-to-back with no pop -> first 4 accepted, full=1, 5th dropped, overflow=1 and stays 1 after FIFO drains.
REQ-034 FIFO full, push coincident with pop edge at end of IDLE -> count stays 4, overflow stays 0, pushed byte transmitted last.
REQ-035 Assert reset during DATA bit 3 of 0xA5 with 2 bytes queued -> txd=1 next cycle, empty=1, busy=0; no further frames without new pushes.
REQ-036 Push 12 bytes spaced to never overflow -> pointers wrap 3 times; all 12 bytes received in order, no loss.
